// File: rtl/cpu_pkg.sv
// Shared constants and types for the fetch stage: widths, opcode field
// location, the halt opcode and the fetch FSM state encoding.
package cpu_pkg;

  localparam int ADDR_W     = 8;
  localparam int INSTR_W    = 17;
  localparam int CNT_W      = 16;
  localparam int OPCODE_MSB = 16;
  localparam int OPCODE_LSB = 12;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [OPCODE_W-1:0] HALT_OPCODE = 5'b00111;
  localparam logic [ADDR_W-1:0]   RESET_PC    = 8'h00;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/fetch_pc.sv
// Program counter register: redirect to a target, increment (wrapping) or hold.
module fetch_pc #(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_target,
  input  logic [ADDR_W-1:0] target,
  input  logic              incr,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Redirect wins over increment; the increment wraps naturally at 2^ADDR_W.
  always_comb begin
    pc_d = pc_q;
    if (load_target) begin
      pc_d = target;
    end else if (incr) begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule : fetch_pc

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, captures memory data into the IR and
// hands it to decode over valid/ready, with branch flush and halt detection.
module fetch_unit #(
  parameter int                 ADDR_W      = cpu_pkg::ADDR_W,
  parameter int                 INSTR_W     = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC    = cpu_pkg::RESET_PC,
  parameter logic [4:0]         HALT_OPCODE = cpu_pkg::HALT_OPCODE,
  parameter int                 CNT_W       = cpu_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  prg_counter,
  input  logic [INSTR_W-1:0] instructions,
  output logic [INSTR_W-1:0] ir_instr,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               dec_ready,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  import cpu_pkg::*;

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] ir_instr_q, ir_instr_d;
  logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
  logic               ir_valid_q, ir_valid_d;
  logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;

  logic run;
  logic redirect;
  logic load;
  logic halt_word;
  logic pc_incr;

  assign run       = (state_q == FETCH_RUN);
  assign redirect  = run && branch_taken;
  assign load      = run && !branch_taken && (!ir_valid_q || dec_ready);
  assign halt_word = (instructions[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);
  // A halt word freezes the PC on its own address.
  assign pc_incr   = load && !halt_word;

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .clk         (clk),
    .reset       (reset),
    .load_target (redirect),
    .target      (branch_target),
    .incr        (pc_incr),
    .pc          (prg_counter)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_RUN:  if (load && halt_word) state_d = FETCH_HALT;
      FETCH_HALT: state_d = FETCH_HALT;
      default:    state_d = FETCH_RUN;
    endcase
  end

  always_comb begin
    ir_instr_d    = ir_instr_q;
    ir_pc_d       = ir_pc_q;
    ir_valid_d    = ir_valid_q;
    fetch_count_d = fetch_count_q;
    if (load) begin
      ir_instr_d    = instructions;
      ir_pc_d       = prg_counter;
      ir_valid_d    = 1'b1;
      fetch_count_d = (&fetch_count_q) ? fetch_count_q : fetch_count_q + 1'b1;
    end else if (redirect) begin
      ir_valid_d = 1'b0;
    end else if (ir_valid_q && dec_ready) begin
      // Consume with nothing to replace it (only reachable in HALT).
      ir_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH_RUN;
      ir_instr_q    <= '0;
      ir_pc_q       <= '0;
      ir_valid_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ir_instr_q    <= ir_instr_d;
      ir_pc_q       <= ir_pc_d;
      ir_valid_q    <= ir_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign ir_instr    = ir_instr_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign halted      = (state_q == FETCH_HALT);
  assign fetch_count = fetch_count_q;

endmodule : fetch_unit

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that owns the program counter and drives `prg_counter` into the combinational instruction memory.
- Captures the returned 17-bit word into an instruction register with its PC, and presents it to decode over a valid/ready handshake.
- Handles branch redirect/flush, halt-opcode detection and a saturating fetch counter.

Parameters:
- ADDR_W, 8, program-counter / instruction-memory address width
- INSTR_W, 17, instruction width
- RESET_PC, 8'h00, PC value loaded on reset
- HALT_OPCODE, 5'b00111, opcode value (`instr[16:12]`) that halts fetch
- CNT_W, 16, fetch counter width

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- prg_counter  output  ADDR_W  address to instruction memory (the PC register)
- instructions  input  INSTR_W  combinational memory data for `prg_counter`
- ir_instr  output  INSTR_W  registered instruction to decode
- ir_pc  output  ADDR_W  address from which `ir_instr` was fetched
- ir_valid  output  1  `ir_instr`/`ir_pc` hold an unconsumed instruction
- dec_ready  input  1  decode accepts `ir_instr` this cycle when `ir_valid`=1
- branch_taken  input  1  redirect request, one-cycle pulse
- branch_target  input  ADDR_W  redirect address, valid with `branch_taken`
- halted  output  1  fetch stopped by halt opcode
- fetch_count  output  CNT_W  number of instructions loaded into IR, saturating

Behaviour:
- Clock/reset: one clock, `clk`. Reset is synchronous and active-high on `reset`.
- Reset values:
  - `prg_counter`=RESET_PC
  - `ir_instr`=0, `ir_pc`=0, `ir_valid`=0
  - `halted`=0, `fetch_count`=0
  - FSM=RUN
  - Reset asserted mid-operation (including in HALT) overrides everything in that cycle.
- FSM states: RUN, HALT. `halted` = (state==HALT), registered.
- load = (state==RUN) && !branch_taken && (!ir_valid || dec_ready).
- On load:
  - `ir_instr` <= `instructions`; `ir_pc` <= `prg_counter`; `ir_valid` <= 1.
  - `fetch_count` <= `fetch_count`+1, saturating at all-ones.
  - If `instructions[16:12]`==HALT_OPCODE: state <= HALT and `prg_counter` holds.
  - Otherwise `prg_counter` <= `prg_counter`+1, modulo 2^ADDR_W (8'hFF -> 8'h00).
- Latency: memory read is combinational, so an instruction appears in IR one cycle after its address is driven. Steady-state throughput is one instruction per cycle with `dec_ready`=1.
- Backpressure: `ir_valid`=1 && `dec_ready`=0 -> `ir_instr`, `ir_pc`, `prg_counter`, `fetch_count` all hold.
- Consume without load: `ir_valid`=1 && `dec_ready`=1 && !load -> `ir_valid` <= 0.
- Branch, in RUN only: `branch_taken`=1 -> `prg_counter` <= `branch_target` and `ir_valid` <= 0 (flush, regardless of `dec_ready`).
  - No load that cycle; `fetch_count` unchanged.
  - Branch has priority over load and halt detection: a halt word present that cycle is discarded and no halt occurs.
- HALT:
  - No loads; `branch_taken` ignored; `prg_counter` frozen at the halt instruction's address.
  - The halt instruction stays in IR until consumed, then `ir_valid`=0 permanently.
  - Only `reset` exits HALT.
- `ir_valid` never drops without a consume, branch or reset.

Decomposition:
- Shared package `cpu_pkg`:
  - ADDR_W, INSTR_W
  - OPCODE_MSB=16, OPCODE_LSB=12
  - HALT_OPCODE constant
  - fetch state enum {RUN, HALT}
- One natural sub-module: `fetch_pc`, the PC register with sync reset, load-target, increment and hold controls.
- The IR, FSM and counter stay in `fetch_unit`.

Test Plan:
- Reset, then release with `dec_ready`=1 and mem[0]=17'h12200, mem[1]=17'h08844 -> cycle 1: `ir_pc`=0, `ir_instr`=17'h12200, `prg_counter`=1; cycle 2: `ir_pc`=1, `ir_instr`=17'h08844; `fetch_count`=2.
- Backpressure: `dec_ready`=0 for 3 cycles with `ir_valid`=1 -> `ir_instr`/`ir_pc`/`prg_counter`/`fetch_count` constant. Then `dec_ready`=1 -> next instruction loads on the next edge.
- Branch: `branch_taken`=1, `branch_target`=8'h40 -> next cycle `prg_counter`=8'h40, `ir_valid`=0; following cycle `ir_pc`=8'h40, `ir_valid`=1.
- Halt: mem[5]=17'b00111000000000000 -> after loading: `halted`=1, `ir_pc`=5, `prg_counter`=5. A `branch_taken` pulse then has no effect. After consume, `ir_valid`=0 and stays 0.
- Wrap and priority:
  - Branch to 8'hFF, then load -> `prg_counter`=8'h00.
  - `branch_taken` in the same cycle mem[PC] holds the halt word -> `halted` stays 0, PC = target.
- Reset in HALT -> all outputs at reset values next cycle; fetch resumes from RESET_PC.
